// File: rtl/datapath_pkg.sv
// Shared encodings for the single-bus datapath: op codes, sequencer states and bus sources.
package datapath_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StLdy,
    StExec,
    StWblo,
    StWbhi
  } seq_state_e;

  // One-hot bus source select; all-zero drives the bus to 0.
  localparam int unsigned BusSelW     = 4;
  localparam int unsigned BusRegIdx   = 0;
  localparam int unsigned BusZloIdx   = 1;
  localparam int unsigned BusZhiIdx   = 2;
  localparam int unsigned BusMdataIdx = 3;
  typedef logic [BusSelW-1:0] bus_sel_t;

  localparam bus_sel_t BusNone  = 4'b0000;
  localparam bus_sel_t BusReg   = 4'b0001;
  localparam bus_sel_t BusZlo   = 4'b0010;
  localparam bus_sel_t BusZhi   = 4'b0100;
  localparam bus_sel_t BusMdata = 4'b1000;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU producing a 2W-bit {hi, lo} result; only MUL populates hi.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned ShW = $clog2(W);

  logic [2*W-1:0] z;

  always_comb begin
    z = '0;
    case (op)
      OP_ADD:  z[W-1:0] = a + b;
      OP_SUB:  z[W-1:0] = a - b;
      OP_AND:  z[W-1:0] = a & b;
      OP_OR:   z[W-1:0] = a | b;
      OP_SHL:  z[W-1:0] = a << b[ShW-1:0];
      OP_SHR:  z[W-1:0] = a >> b[ShW-1:0];
      OP_MUL:  z = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      default: z = '0;
    endcase
  end

  assign hi = z[2*W-1:W];
  assign lo = z[W-1:0];

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with register file, Y/Z staging, HI/LO and a micro-sequencer
// running Rd <= Ra OP Rb one bus source per cycle, plus a one-cycle memory load path.
module bus_datapath_seq
  import datapath_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned NREG    = 16,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [2:0]              op_code,
  input  logic [$clog2(NREG)-1:0] op_ra,
  input  logic [$clog2(NREG)-1:0] op_rb,
  input  logic [$clog2(NREG)-1:0] op_rd,
  input  logic                    ld_valid,
  input  logic [$clog2(NREG)-1:0] ld_rd,
  input  logic [W-1:0]            MdataIn,
  output logic                    done,
  output logic                    err,
  output logic [W-1:0]            bus_out,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [W-1:0]            dbg_data,
  output logic [W-1:0]            hi_out,
  output logic [W-1:0]            lo_out
);

  localparam int unsigned RW = $clog2(NREG);

  seq_state_e     state_q;
  logic [2:0]     code_q;
  logic [RW-1:0]  ra_q, rb_q, rd_q;
  logic [W-1:0]   y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic [W-1:0]   regs_q [NREG];
  logic           done_q, err_q;

  logic [RW-1:0]  src_idx;
  logic [W-1:0]   reg_rdata;
  logic           ld_take;
  bus_sel_t       bus_sel;
  logic [W-1:0]   bus;
  logic [W-1:0]   alu_hi, alu_lo;
  logic           is_mul, is_ill;

  assign op_ready = (state_q == StIdle);
  assign ld_take  = (state_q == StIdle) && ld_valid && !op_valid;
  assign is_mul   = (code_q == OP_MUL);
  assign is_ill   = (code_q == OP_ILL);

  assign src_idx   = (state_q == StExec) ? rb_q : ra_q;
  assign reg_rdata = (R0_ZERO && src_idx == '0) ? '0 : regs_q[src_idx];
  assign dbg_data  = (R0_ZERO && dbg_sel == '0) ? '0 : regs_q[dbg_sel];

  always_comb begin
    bus_sel = BusNone;
    unique case (state_q)
      StIdle:         bus_sel = ld_take ? BusMdata : BusNone;
      StLdy, StExec:  bus_sel = BusReg;
      StWblo:         bus_sel = BusZlo;
      StWbhi:         bus_sel = BusZhi;
      default:        bus_sel = BusNone;
    endcase
  end

  assign bus = ({W{bus_sel[BusRegIdx]}}   & reg_rdata)
             | ({W{bus_sel[BusZloIdx]}}   & zlo_q)
             | ({W{bus_sel[BusZhiIdx]}}   & zhi_q)
             | ({W{bus_sel[BusMdataIdx]}} & MdataIn);

  dp_alu #(
    .W (W)
  ) u_alu (
    .a  (y_q),
    .b  (bus),
    .op (code_q),
    .hi (alu_hi),
    .lo (alu_lo)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      code_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A command beats a simultaneous load; the load must be re-presented.
          if (op_valid) begin
            code_q  <= op_code;
            ra_q    <= op_ra;
            rb_q    <= op_rb;
            rd_q    <= op_rd;
            state_q <= StLdy;
          end else if (ld_valid) begin
            if (!(R0_ZERO && ld_rd == '0)) begin
              regs_q[ld_rd] <= bus;
            end
            done_q <= 1'b1;
          end
        end
        StLdy: begin
          y_q     <= bus;
          state_q <= StExec;
        end
        StExec: begin
          zhi_q   <= alu_hi;
          zlo_q   <= alu_lo;
          state_q <= StWblo;
        end
        StWblo: begin
          if (is_mul) begin
            lo_q    <= bus;
            state_q <= StWbhi;
          end else begin
            if (!is_ill && !(R0_ZERO && rd_q == '0)) begin
              regs_q[rd_q] <= bus;
            end
            done_q  <= 1'b1;
            err_q   <= is_ill;
            state_q <= StIdle;
          end
        end
        StWbhi: begin
          hi_q    <= bus;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign bus_out = bus;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Scoreboard bench: two DUTs (R0_ZERO=0 and 1) share stimulus; a monitor checks done/err/latency.
module tb_bus_datapath_seq;

  localparam int unsigned W    = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned RW   = 4;

  localparam logic [2:0] C_ADD = 3'd0;
  localparam logic [2:0] C_SUB = 3'd1;
  localparam logic [2:0] C_AND = 3'd2;
  localparam logic [2:0] C_OR  = 3'd3;
  localparam logic [2:0] C_SHL = 3'd4;
  localparam logic [2:0] C_SHR = 3'd5;
  localparam logic [2:0] C_MUL = 3'd6;
  localparam logic [2:0] C_ILL = 3'd7;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          op_valid = 1'b0;
  logic [2:0]    op_code = '0;
  logic [RW-1:0] op_ra = '0, op_rb = '0, op_rd = '0;
  logic          ld_valid = 1'b0;
  logic [RW-1:0] ld_rd = '0;
  logic [W-1:0]  mdata = '0;
  logic [RW-1:0] dbg_sel = '0;

  logic          a_ready, a_done, a_err, z_ready, z_done, z_err;
  logic [W-1:0]  a_bus, a_dbg, a_hi, a_lo, z_bus, z_dbg, z_hi, z_lo;

  always #5 clk = ~clk;

  bus_datapath_seq #(.W(W), .NREG(NREG), .R0_ZERO(1'b0)) u_dut (
    .clk(clk), .clr(clr), .op_valid(op_valid), .op_ready(a_ready), .op_code(op_code),
    .op_ra(op_ra), .op_rb(op_rb), .op_rd(op_rd), .ld_valid(ld_valid), .ld_rd(ld_rd),
    .MdataIn(mdata), .done(a_done), .err(a_err), .bus_out(a_bus), .dbg_sel(dbg_sel),
    .dbg_data(a_dbg), .hi_out(a_hi), .lo_out(a_lo)
  );

  bus_datapath_seq #(.W(W), .NREG(NREG), .R0_ZERO(1'b1)) u_dut_z (
    .clk(clk), .clr(clr), .op_valid(op_valid), .op_ready(z_ready), .op_code(op_code),
    .op_ra(op_ra), .op_rb(op_rb), .op_rd(op_rd), .ld_valid(ld_valid), .ld_rd(ld_rd),
    .MdataIn(mdata), .done(z_done), .err(z_err), .bus_out(z_bus), .dbg_sel(dbg_sel),
    .dbg_data(z_dbg), .hi_out(z_hi), .lo_out(z_lo)
  );

  // acc = edge number of the accepting edge; lat = edges from it to the start of the done cycle.
  typedef struct {
    bit err;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_done_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_done || z_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=%b/%b want no done", a_done, z_done);
      end else begin
        mon_e = sb.pop_front();
        check("done_both", 32'({a_done, z_done}), 32'd3);
        check("err_a", 32'(a_err), 32'(mon_e.err));
        check("err_z", 32'(z_err), 32'(mon_e.err));
        check("done_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
      last_done_cyc = cyc;
    end
  end

  task automatic load(input logic [RW-1:0] rd, input logic [W-1:0] d);
    @(negedge clk); #1;
    ld_valid = 1'b1;
    ld_rd    = rd;
    mdata    = d;
    #1;
    check("ld_ready", 32'(a_ready), 32'd1);
    check("ld_bus", a_bus, d);
    sb.push_back('{err: 1'b0, acc: cyc + 1, lat: 0});
    @(negedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] code, input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                       input logic [RW-1:0] rd, input bit e, input int lat, input bit b2b,
                       input bit expect_done);
    int n;
    n = 0;
    @(negedge clk); #1;
    op_valid = 1'b1;
    op_code  = code;
    op_ra    = ra;
    op_rb    = rb;
    op_rd    = rd;
    while (!a_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!a_ready) begin
      total++;
      bad++;
      $display("FAIL op_accept_timeout: got ready=0 want ready=1");
      op_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_accept_in_done_cycle", 32'(cyc), 32'(last_done_cyc));
    if (expect_done) sb.push_back('{err: e, acc: cyc + 1, lat: lat});
    @(negedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reg(input string name, input logic [RW-1:0] idx, input logic [W-1:0] ea,
                         input logic [W-1:0] ez);
    dbg_sel = idx;
    #1;
    check({name, "_a"}, a_dbg, ea);
    check({name, "_z"}, z_dbg, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready_a", 32'(a_ready), 32'd1);
    check("rst_ready_z", 32'(z_ready), 32'd1);
    check("rst_done", 32'({a_done, a_err, z_done, z_err}), 32'd0);
    check("rst_bus", a_bus, '0);
    check("rst_hi", a_hi, '0);
    check("rst_lo", a_lo, '0);
    chk_reg("rst_r1", 4'd1, '0, '0);
    clr = 1'b0;

    // 1: loads then ADD
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    do_op(C_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 3, 1'b0, 1'b1);
    wait_idle();
    chk_reg("add_r3", 4'd3, 32'd12, 32'd12);
    check("idle_bus", a_bus, '0);

    // 2: MUL full product, rd ignored
    load(4'd1, 32'hFFFF_FFFF);
    load(4'd2, 32'hFFFF_FFFF);
    do_op(C_MUL, 4'd1, 4'd2, 4'd3, 1'b0, 4, 1'b0, 1'b1);
    wait_idle();
    check("mul_lo", a_lo, 32'h0000_0001);
    check("mul_hi", a_hi, 32'hFFFF_FFFE);
    check("mul_hi_z", z_hi, 32'hFFFF_FFFE);
    chk_reg("mul_r3_untouched", 4'd3, 32'd12, 32'd12);

    // 3: SUB wrap, shifts use low 5 bits of B, OR
    load(4'd1, 32'd0);
    load(4'd2, 32'd1);
    do_op(C_SUB, 4'd1, 4'd2, 4'd5, 1'b0, 3, 1'b0, 1'b1);
    wait_idle();
    chk_reg("sub_r5", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    load(4'd2, 32'd33);
    load(4'd1, 32'd3);
    do_op(C_SHL, 4'd1, 4'd2, 4'd6, 1'b0, 3, 1'b0, 1'b1);
    do_op(C_SHR, 4'd2, 4'd1, 4'd7, 1'b0, 3, 1'b1, 1'b1);
    do_op(C_OR, 4'd1, 4'd2, 4'd9, 1'b0, 3, 1'b1, 1'b1);
    wait_idle();
    chk_reg("shl_r6", 4'd6, 32'd6, 32'd6);
    chk_reg("shr_r7", 4'd7, 32'd4, 32'd4);
    chk_reg("or_r9", 4'd9, 32'd35, 32'd35);

    // 4: illegal op, then op+load together (load dropped)
    load(4'd4, 32'h55);
    do_op(C_ILL, 4'd1, 4'd2, 4'd4, 1'b1, 3, 1'b0, 1'b1);
    ld_valid = 1'b1;
    ld_rd    = 4'd8;
    mdata    = 32'hDEAD;
    do_op(C_AND, 4'd1, 4'd2, 4'd10, 1'b0, 3, 1'b1, 1'b1);
    ld_valid = 1'b0;
    wait_idle();
    chk_reg("ill_r4_kept", 4'd4, 32'h55, 32'h55);
    chk_reg("and_r10", 4'd10, 32'd1, 32'd1);
    chk_reg("ld_dropped_r8", 4'd8, '0, '0);

    // 5: clr during EXEC
    do_op(C_ADD, 4'd1, 4'd2, 4'd11, 1'b0, 3, 1'b0, 1'b0);
    @(negedge clk); #1;
    clr = 1'b1;
    #2;
    check("clr_ready", 32'(a_ready), 32'd1);
    clr = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      chk_reg("clr_reg", RW'(i), '0, '0);
    end
    check("clr_hi", a_hi, '0);
    check("clr_lo", a_lo, '0);
    repeat (6) @(negedge clk);
    #1;

    // 6: R0 handling, back-to-back accepts
    load(4'd0, 32'd9);
    chk_reg("r0_load", 4'd0, 32'd9, 32'd0);
    do_op(C_ADD, 4'd0, 4'd0, 4'd1, 1'b0, 3, 1'b0, 1'b1);
    do_op(C_OR, 4'd1, 4'd0, 4'd2, 1'b0, 3, 1'b1, 1'b1);
    do_op(C_ADD, 4'd2, 4'd2, 4'd0, 1'b0, 3, 1'b1, 1'b1);
    wait_idle();
    chk_reg("r0_final", 4'd0, 32'd54, 32'd0);
    chk_reg("r0_r1", 4'd1, 32'd18, 32'd0);
    chk_reg("r0_r2", 4'd2, 32'd27, 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
